// File: rtl/barcode_scan_controller_pkg.sv
// Shared types and constants for the barcode scan controller and its column scanner.
// Holds the FSM state encoding, matrix/code geometry and the 2-of-5 popcount helper.
package bcs_pkg;

   typedef enum logic [1:0] {IDLE, SETTLE, CHECK, SHOW} state_t;

   localparam int MATRIX_COLS = 5;
   localparam int MATRIX_ROWS = 7;
   localparam int CODE_W      = 8;
   localparam int SYM_W       = 5;

   function automatic logic [2:0] popcount5(input logic [SYM_W-1:0] sym);
      logic [2:0] n;
      n = '0;
      for (int i = 0; i < SYM_W; i++) n = n + {2'b00, sym[i]};
      return n;
   endfunction

endpackage

// File: rtl/barcode_scan_controller_if.sv
// Switch input and decoder/indicator outputs of the barcode scan controller.
// No backpressure: code_valid is a single-cycle pulse with no ready.
interface barcode_scan_controller_if;
   import bcs_pkg::*;

   logic [CODE_W-1:0]      code_in;
   logic [CODE_W-1:0]      code_q;
   logic                   code_valid;
   logic                   code_ok;
   logic                   led_g;
   logic                   led_r;
   logic                   disp_en;
   logic [MATRIX_COLS-1:0] col_sel;
   logic [2:0]             col_idx;
   logic                   busy;

   modport master (
      output code_in,
      input  code_q, code_valid, code_ok, led_g, led_r, disp_en, col_sel, col_idx, busy
   );

   modport slave (
      input  code_in,
      output code_q, code_valid, code_ok, led_g, led_r, disp_en, col_sel, col_idx, busy
   );
endinterface

// File: rtl/barcode_scan_controller_scanner.sv
// Free-running one-hot column scanner for the 5-column LED matrix.
// col_idx steps every SCAN_DIV cycles in all states; col_sel is gated by en with no extra latency.
module matrix_col_scanner
   import bcs_pkg::*;
#(
   parameter int SCAN_DIV = 10_000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   output logic [MATRIX_COLS-1:0] col_sel,
   output logic [2:0]             col_idx
);
   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [2:0]       col_idx_q, col_idx_d;
   logic             wrap;

   always_comb begin
      wrap      = (div_cnt_q == DIV_W'(SCAN_DIV - 1));
      div_cnt_d = wrap ? '0 : div_cnt_q + 1'b1;
      col_idx_d = col_idx_q;
      if (wrap) col_idx_d = (col_idx_q == 3'(MATRIX_COLS - 1)) ? 3'd0 : col_idx_q + 3'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q <= '0;
         col_idx_q <= '0;
      end else begin
         div_cnt_q <= div_cnt_d;
         col_idx_q <= col_idx_d;
      end
   end

   assign col_idx = col_idx_q;
   assign col_sel = en ? (MATRIX_COLS'(1) << col_idx_q) : '0;
endmodule

// File: rtl/barcode_scan_controller.sv
// Debounces the switch code, latches/checks it and drives LEDs and the matrix scan for a hold window.
// Input edge to code_valid: 2 + DEB_CYCLES + 1 cycles; no backpressure, outputs are registered.
module barcode_scan_controller
   import bcs_pkg::*;
#(
   parameter int DEB_CYCLES  = 50_000,
   parameter int HOLD_CYCLES = 25_000_000,
   parameter int SCAN_DIV    = 10_000
) (
   input logic                      clk,
   input logic                      rst_n,
   barcode_scan_controller_if.slave bus
);
   localparam int DEB_W  = $clog2(DEB_CYCLES);
   localparam int HOLD_W = $clog2(HOLD_CYCLES);
   localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEB_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES - 1);

   state_t              state_q, state_d;
   logic [CODE_W-1:0]   meta_q, meta_d, sync_q, sync_d, code_lat_q, code_lat_d;
   logic [DEB_W-1:0]    deb_cnt_q, deb_cnt_d;
   logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic                code_ok_q, code_ok_d, code_valid_q, code_valid_d;
   logic                led_g_q, led_g_d, led_r_q, led_r_d, disp_en_q, disp_en_d, busy_q, busy_d;

   always_comb begin
      meta_d = bus.code_in;
      sync_d = meta_q;
      // Cleared on the same edge the synchronised value changes, so it counts stable cycles.
      if (meta_q != sync_q)         deb_cnt_d = '0;
      else if (deb_cnt_q != DEB_MAX) deb_cnt_d = deb_cnt_q + 1'b1;
      else                           deb_cnt_d = deb_cnt_q;

      state_d      = state_q;
      code_lat_d   = code_lat_q;
      code_ok_d    = code_ok_q;
      code_valid_d = 1'b0;
      hold_cnt_d   = hold_cnt_q;

      unique case (state_q)
         IDLE: if (sync_q != code_lat_q) state_d = SETTLE;
         SETTLE: begin
            if (sync_q == code_lat_q) begin
               state_d = IDLE;
            end else if (deb_cnt_q == DEB_MAX) begin
               code_lat_d = sync_q;
               state_d    = CHECK;
            end
         end
         CHECK: begin
            code_ok_d = (popcount5(code_lat_q[SYM_W-1:0]) == 3'd2);
            if (code_lat_q == '0) begin
               state_d = IDLE;
            end else begin
               code_valid_d = 1'b1;
               hold_cnt_d   = '0;
               state_d      = SHOW;
            end
         end
         SHOW: begin
            if (sync_q != code_lat_q)      state_d = SETTLE;
            else if (hold_cnt_q == HOLD_MAX) state_d = IDLE;
            else                           hold_cnt_d = hold_cnt_q + 1'b1;
         end
      endcase

      led_g_d   = (state_d == SHOW) && code_ok_d;
      led_r_d   = (state_d == SHOW) && !code_ok_d;
      disp_en_d = (state_d == SHOW) && code_ok_d;
      busy_d    = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         meta_q       <= '0;
         sync_q       <= '0;
         code_lat_q   <= '0;
         deb_cnt_q    <= '0;
         hold_cnt_q   <= '0;
         code_ok_q    <= 1'b0;
         code_valid_q <= 1'b0;
         led_g_q      <= 1'b0;
         led_r_q      <= 1'b0;
         disp_en_q    <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         meta_q       <= meta_d;
         sync_q       <= sync_d;
         code_lat_q   <= code_lat_d;
         deb_cnt_q    <= deb_cnt_d;
         hold_cnt_q   <= hold_cnt_d;
         code_ok_q    <= code_ok_d;
         code_valid_q <= code_valid_d;
         led_g_q      <= led_g_d;
         led_r_q      <= led_r_d;
         disp_en_q    <= disp_en_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.code_q     = code_lat_q;
   assign bus.code_ok    = code_ok_q;
   assign bus.code_valid = code_valid_q;
   assign bus.led_g      = led_g_q;
   assign bus.led_r      = led_r_q;
   assign bus.disp_en    = disp_en_q;
   assign bus.busy       = busy_q;

   matrix_col_scanner #(.SCAN_DIV(SCAN_DIV)) u_scan (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (state_q == SHOW),
      .col_sel (bus.col_sel),
      .col_idx (bus.col_idx)
   );
endmodule
